// File: rtl/div_pkg.sv
// div_pkg: shared width default, FSM encoding and request word layout for div_scheduler
package div_pkg;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {ST_FLUSH, ST_IDLE, ST_WAIT} state_t;

    // Request word is {sign, dividend, divisor} with the divisor in the LSBs.
    function automatic int req_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int sign_pos(input int w);
        return 2 * w;
    endfunction

    function automatic int dvd_lsb(input int w);
        return w;
    endfunction
endpackage

// File: rtl/div_scheduler_req_fifo.sv
// req_fifo: synchronous FIFO holding divide requests
//   clk, reset       : clock, synchronous active-high reset
//   push/wdata       : write strobe and data (caller never pushes when full)
//   pop/rdata        : read strobe and head-of-queue data (caller never pops when empty)
//   full/empty/count : occupancy status
module req_fifo #(
    parameter int DW    = 17,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;

    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdata;
    end

    assign rdata = mem[rp];
    assign full  = count == (AW + 1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/div_scheduler.sv
// div_scheduler: request FIFO, issue FSM and result register in front of a shared iterative divider
//   clk, reset                          : clock, synchronous active-high reset
//   in_valid/in_ready, in_sign/in_dividend/in_divisor : request handshake and operands
//   out_valid/out_ready, out_quotient/out_remainder/out_div0 : result handshake and payload
//   busy                                : any request queued, in flight or waiting downstream
//   div_start, div_sign/div_dividend/div_divisor : divider start pulse and operands
//   div_quotient/div_remainder/div_ready : divider results and done pulse
module div_scheduler
    import div_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = WIDTH + 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_div0,
    output logic             busy,
    output logic             div_start,
    output logic             div_sign,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    input  logic             div_ready
);
    localparam int RW = req_w(WIDTH);
    localparam int SB = sign_pos(WIDTH);
    localparam int DL = dvd_lsb(WIDTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = $clog2(FLUSH_CYCLES + 2);

    state_t           state, state_nx;
    logic [FW-1:0]    flush_cnt;
    logic [RW-1:0]    head;
    logic             full, empty, push, take, zdiv, start, done;
    logic [CW-1:0]    count;
    logic             op_sign;
    logic [WIDTH-1:0] op_dvd, op_dvs, h_dvd, h_dvs;

    req_fifo #(.DW(RW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (take),
        .wdata ({in_sign, in_dividend, in_divisor}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign h_dvd = head[DL +: WIDTH];
    assign h_dvs = head[WIDTH-1:0];

    assign in_ready = state != ST_FLUSH && !full;
    assign push     = in_valid && in_ready;
    // The head may be consumed when the result register is free or being emptied this cycle.
    assign take     = state == ST_IDLE && !empty && (!out_valid || out_ready);
    assign zdiv     = take && h_dvs == '0;
    assign start    = take && h_dvs != '0;
    assign done     = state == ST_WAIT && div_ready;
    assign busy     = count != '0 || state != ST_IDLE || out_valid;

    // Operands come straight from the FIFO head in the start cycle, then from the
    // latched copy, so they are stable from div_start until div_ready.
    assign div_start    = start;
    assign div_sign     = start ? head[SB] : op_sign;
    assign div_dividend = start ? h_dvd : op_dvd;
    assign div_divisor  = start ? h_dvs : op_dvs;

    always_comb begin
        state_nx = state;
        if (state == ST_FLUSH && flush_cnt <= FW'(1)) state_nx = ST_IDLE;
        if (start) state_nx = ST_WAIT;
        if (done) state_nx = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_FLUSH;
            flush_cnt     <= FW'(FLUSH_CYCLES);
            op_sign       <= 1'b0;
            op_dvd        <= '0;
            op_dvs        <= '0;
            out_valid     <= 1'b0;
            out_div0      <= 1'b0;
            out_quotient  <= '0;
            out_remainder <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
            if (start) {op_sign, op_dvd, op_dvs} <= head;
            if (done) begin
                out_valid     <= 1'b1;
                out_div0      <= 1'b0;
                out_quotient  <= div_quotient;
                out_remainder <= div_remainder;
            end else if (zdiv) begin
                out_valid     <= 1'b1;
                out_div0      <= 1'b1;
                out_quotient  <= '1;
                out_remainder <= h_dvd;
            end else if (out_ready) begin
                out_valid     <= 1'b0;
            end
        end
    end
endmodule
